// File: rtl/vrf_write_scheduler.sv
// Write-port owner for the 8x256-bit vector register file.
// Round-robin arbitrates ALU and load writebacks onto one registered write
// port, keeps the per-register busy scoreboard reserved by issue, and raises
// a combinational hazard so issue can stall on RAW/WAW conflicts.
module vrf_write_scheduler #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    output logic              hazard,
    output logic [NREGS-1:0]  busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd
);

    // Highest register index aliases the PC; it is never tracked as busy.
    localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(NREGS - 1);

    logic             prio_alu;
    logic             alu_grant;
    logic             mem_grant;
    logic             src1_busy;
    logic             src2_busy;
    logic             rsv_busy;
    logic             rsv_set;
    logic [NREGS-1:0] busy_next;

    // Round-robin arbiter: single requester always wins, ties go to the one not granted last.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!reset) begin
            if (alu_valid && (!mem_valid || prio_alu)) begin
                alu_grant = 1'b1;
            end else if (mem_valid) begin
                mem_grant = 1'b1;
            end
        end
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // Hazard lookup; PC alias reads never stall.
    always_comb begin
        src1_busy = (src1_addr != PC_REG) && busy[src1_addr];
        src2_busy = (src2_addr != PC_REG) && busy[src2_addr];
        rsv_busy  = rsv_valid && (rsv_addr != PC_REG) && busy[rsv_addr];
        hazard    = src1_busy || src2_busy || rsv_busy;
        rsv_set   = rsv_valid && !hazard && (rsv_addr != PC_REG);
    end

    // Scoreboard update: retire the write in flight, then apply a new reservation (set wins).
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_wa] = 1'b0;
        end
        if (rsv_set) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Round-robin pointer moves only when someone is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_alu <= 1'b1;
        end else if (alu_grant) begin
            prio_alu <= 1'b0;
        end else if (mem_grant) begin
            prio_alu <= 1'b1;
        end
    end

    // Registered write port; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= alu_grant || mem_grant;
            if (alu_grant) begin
                rf_wa <= alu_addr;
                rf_wd <= alu_data;
            end else if (mem_grant) begin
                rf_wa <= mem_addr;
                rf_wd <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_vrf_write_scheduler.sv
// Scoreboard bench for vrf_write_scheduler: a cycle-level reference model
// predicts grants, hazards and busy bits; expected register-file writes are
// queued with their due cycle and checked by an independent monitor.
module tb_vrf_write_scheduler;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREGS  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] src1_addr;
    logic [ADDR_W-1:0] src2_addr;
    logic              hazard;
    logic [NREGS-1:0]  busy;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    vrf_write_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .src1_addr(src1_addr), .src2_addr(src2_addr),
        .hazard(hazard), .busy(busy),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                due;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  mon_en = 1'b0;

    // Reference model state
    bit [NREGS-1:0]  m_busy = '0;
    bit              m_last_alu = 1'b0;
    bit              m_infl = 1'b0;
    bit [ADDR_W-1:0] m_infl_addr = '0;

    // Pending requesters (held until granted)
    bit              pa = 1'b0, pm = 1'b0;
    bit [ADDR_W-1:0] paa = '0, pma = '0;
    bit [DATA_W-1:0] pad = '0, pmd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand256();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // One clock cycle: drive pending requests plus issue-side inputs, check against the model.
    task automatic step(input bit rst, input bit rv, input bit [ADDR_W-1:0] ra,
                        input bit [ADDR_W-1:0] s1, input bit [ADDR_W-1:0] s2);
        bit ga, gm, hz;
        bit [NREGS-1:0] nb;
        reset = rst;
        alu_valid = pa; alu_addr = paa; alu_data = pad;
        mem_valid = pm; mem_addr = pma; mem_data = pmd;
        rsv_valid = rv; rsv_addr = ra; src1_addr = s1; src2_addr = s2;
        #1;
        ga = 1'b0; gm = 1'b0;
        if (!rst) begin
            if (pa && pm) begin ga = !m_last_alu; gm = m_last_alu; end
            else begin ga = pa; gm = pm; end
        end
        hz = (s1 != 3'd7 && m_busy[s1]) || (s2 != 3'd7 && m_busy[s2]) ||
             (rv && ra != 3'd7 && m_busy[ra]);
        chk("alu_ready", DATA_W'(alu_ready), DATA_W'(ga));
        chk("mem_ready", DATA_W'(mem_ready), DATA_W'(gm));
        chk("hazard", DATA_W'(hazard), DATA_W'(hz));
        chk("busy", DATA_W'(busy), DATA_W'(m_busy));
        nb = m_busy;
        if (m_infl) nb[m_infl_addr] = 1'b0;
        if (rv && !hz && ra != 3'd7) nb[ra] = 1'b1;
        if (ga) exp_q.push_back('{a: paa, d: pad, due: cyc + 1});
        if (gm) exp_q.push_back('{a: pma, d: pmd, due: cyc + 1});
        if (ga || gm) m_last_alu = ga;
        m_infl = ga || gm;
        m_infl_addr = ga ? paa : pma;
        if (ga) pa = 1'b0;
        if (gm) pm = 1'b0;
        if (rst) begin
            nb = '0; m_last_alu = 1'b0; m_infl = 1'b0; pa = 1'b0; pm = 1'b0;
        end
        @(posedge clk);
        m_busy = nb;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0);
    endtask

    // Monitor: a write is expected exactly in the cycle its grant was due; otherwise port holds.
    initial begin : monitor
        logic [ADDR_W-1:0] hold_a = '0;
        logic [DATA_W-1:0] hold_d = '0;
        bit exp_we;
        wr_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_we = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                chk("rf_we", DATA_W'(rf_we), DATA_W'(exp_we));
                if (exp_we) begin
                    e = exp_q.pop_front();
                    chk("rf_wa", DATA_W'(rf_wa), DATA_W'(e.a));
                    chk("rf_wd", rf_wd, e.d);
                    hold_a = e.a; hold_d = e.d;
                end else begin
                    chk("rf_wa_hold", DATA_W'(rf_wa), DATA_W'(hold_a));
                    chk("rf_wd_hold", rf_wd, hold_d);
                    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
                end
                if (reset === 1'b1) begin hold_a = '0; hold_d = '0; end
            end
        end
    end

    initial begin : driver
        logic [DATA_W-1:0] a5;
        a5 = {32{8'hA5}};
        reset = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; src1_addr = '0; src2_addr = '0;
        @(posedge clk); #1;
        // Reset two cycles, then the port and scoreboard must be clear.
        step(1'b1, 1'b0, '0, '0, '0);
        mon_en = 1'b1;
        step(1'b1, 1'b0, '0, '0, '0);
        idle(1);
        // Single ALU write.
        pa = 1'b1; paa = 3'd3; pad = a5;
        step(1'b0, 1'b0, '0, '0, '0);
        idle(2);
        // Fresh pointer, both requesters held four cycles.
        step(1'b1, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            pa = 1'b1; paa = 3'd1; pad = rand256();
            pm = 1'b1; pma = 3'd2; pmd = rand256();
            step(1'b0, 1'b0, '0, '0, '0);
        end
        pa = 1'b0; pm = 1'b0;
        idle(2);
        // Reserve 5, stall on source 5, retire via load write.
        step(1'b0, 1'b1, 3'd5, '0, '0);
        step(1'b0, 1'b0, '0, 3'd5, '0);
        pm = 1'b1; pma = 3'd5; pmd = rand256();
        step(1'b0, 1'b0, '0, 3'd5, '0);
        step(1'b0, 1'b0, '0, 3'd5, '0);
        step(1'b0, 1'b0, '0, 3'd5, '0);
        // PC alias reservation ignored; double reservation of 4 stalls.
        step(1'b0, 1'b1, 3'd7, 3'd7, 3'd7);
        step(1'b0, 1'b1, 3'd4, '0, '0);
        step(1'b0, 1'b1, 3'd4, '0, '0);
        step(1'b0, 1'b0, '0, 3'd4, 3'd7);
        // Write to unreserved 2 retiring while 2 is reserved: set wins.
        pa = 1'b1; paa = 3'd2; pad = rand256();
        step(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, 3'd2, '0, '0);
        step(1'b0, 1'b0, '0, 3'd2, '0);
        // Reset while a write is on the port, with a request pending.
        pm = 1'b1; pma = 3'd6; pmd = rand256();
        step(1'b0, 1'b0, '0, '0, '0);
        pa = 1'b1; paa = 3'd0; pad = rand256();
        step(1'b1, 1'b1, 3'd1, '0, '0);
        idle(2);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!pa && ($urandom_range(0, 1) == 1)) begin
                pa = 1'b1; paa = 3'($urandom_range(0, 7)); pad = rand256();
            end
            if (!pm && ($urandom_range(0, 1) == 1)) begin
                pm = 1'b1; pma = 3'($urandom_range(0, 7)); pmd = rand256();
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        pa = 1'b0; pm = 1'b0;
        idle(4);
        chk("queue_drained", DATA_W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
